// File: rtl/i2s_pkg.sv
// Shared I2S receive constants: sample width, synchronizer depth, deserializer state codes
// and the packed FIFO entry layout {channel, sample}.
package i2s_pkg;
    localparam int I2S_SAMPLE_WIDTH = 24;
    localparam int I2S_SYNC_STAGES  = 2;

    localparam logic [1:0] I2S_ST_IDLE = 2'd0;
    localparam logic [1:0] I2S_ST_SYNC = 2'd1;
    localparam logic [1:0] I2S_ST_RUN  = 2'd2;

    typedef struct packed {
        logic                        lr;
        logic [I2S_SAMPLE_WIDTH-1:0] dat;
    } sample_t;
endpackage

// File: rtl/i2s_rx_fifo.sv
// Sample FIFO, 25-bit entries, DEPTH deep (power of two); head readable combinationally.
// A push on full is dropped unless a pop happens in the same cycle; flush empties it in one cycle.
module i2s_rx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        push,
    input  logic [24:0] push_dat,
    input  logic        pop,
    output logic [24:0] pop_dat,
    output logic        full,
    output logic        empty
);
    localparam int AW = $clog2(DEPTH);

    logic [24:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage needs no reset: the head is only visible while the FIFO is non-empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/i2s_reader.sv
// I2S receiver: 2-flop synchronizers, bit-clock edge detect (3 clk pin-to-detect), deserializer, sample FIFO.
// Consumer pops with valid/ack; a push on a full FIFO without a pop is dropped and sets sticky overflow. I2S_READER_STATS_EN adds sample_count.
module i2s_reader
    import i2s_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        i2s_clock,
    input  logic        i2s_lr,
    input  logic        i2s_data,
    output logic [23:0] audio_data,
    output logic        audio_lr_bit,
    output logic        audio_data_valid,
    input  logic        audio_data_ack,
    output logic        overflow
`ifdef I2S_READER_STATS_EN
    ,
    output logic [31:0] sample_count
`endif
);
    localparam int SM = I2S_SYNC_STAGES - 1;

    logic [SM:0] clk_sync;
    logic [SM:0] lr_sync;
    logic [SM:0] dat_sync;
    logic        clk_prev;
    logic        bit_rise;
    logic        lr_s;
    logic        dat_s;

    logic [1:0]                  state;
    logic                        primed;
    logic                        last_lr;
    logic [4:0]                  bit_cnt;
    logic [I2S_SAMPLE_WIDTH-1:0] word;
    logic [I2S_SAMPLE_WIDTH-1:0] word_next;
    logic                        lr_change;

    logic    push;
    logic    pop;
    logic    full;
    logic    empty;
    sample_t push_dat;
    sample_t head;

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_sync <= '0;
            lr_sync  <= '0;
            dat_sync <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[SM-1:0], i2s_clock};
            lr_sync  <= {lr_sync[SM-1:0], i2s_lr};
            dat_sync <= {dat_sync[SM-1:0], i2s_data};
            clk_prev <= clk_sync[SM];
        end
    end

    assign bit_rise  = clk_sync[SM] && !clk_prev;
    assign lr_s      = lr_sync[SM];
    assign dat_s     = dat_sync[SM];
    assign lr_change = (lr_s != last_lr);

    // Bits land at their MSB-first position so short slots come out zero-filled.
    always_comb begin
        word_next = word;
        if (bit_cnt < 5'(I2S_SAMPLE_WIDTH))
            word_next[5'(I2S_SAMPLE_WIDTH - 1) - bit_cnt] = dat_s;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= I2S_ST_IDLE;
            primed  <= 1'b0;
            last_lr <= 1'b0;
            bit_cnt <= '0;
            word    <= '0;
        end else if (!enable) begin
            state   <= I2S_ST_IDLE;
            primed  <= 1'b0;
            bit_cnt <= '0;
            word    <= '0;
        end else begin
            case (state)
                I2S_ST_IDLE: begin
                    primed <= 1'b0;
                    state  <= I2S_ST_SYNC;
                end
                I2S_ST_SYNC: begin
                    // The first edge only records LR; a slot boundary needs a prior reference.
                    if (bit_rise) begin
                        primed  <= 1'b1;
                        last_lr <= lr_s;
                        if (primed && lr_change) state <= I2S_ST_RUN;
                    end
                end
                I2S_ST_RUN: begin
                    if (bit_rise) begin
                        last_lr <= lr_s;
                        if (lr_change) begin
                            bit_cnt <= '0;
                            word    <= '0;
                        end else begin
                            word <= word_next;
                            if (bit_cnt < 5'(I2S_SAMPLE_WIDTH)) bit_cnt <= bit_cnt + 5'd1;
                        end
                    end
                end
                default: state <= I2S_ST_IDLE;
            endcase
        end
    end

    // The bit on the LR-change edge is the LSB of the slot being closed.
    assign push         = enable && (state == I2S_ST_RUN) && bit_rise && lr_change;
    assign push_dat.lr  = last_lr;
    assign push_dat.dat = word_next;
    assign pop          = audio_data_valid && audio_data_ack;

    i2s_rx_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (!enable),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .pop_dat  (head),
        .full     (full),
        .empty    (empty)
    );

    assign audio_data_valid = !empty;
    assign audio_data       = empty ? '0 : head.dat;
    assign audio_lr_bit     = empty ? 1'b0 : head.lr;

    always_ff @(posedge clk) begin
        if (!rst || !enable) overflow <= 1'b0;
        else if (push && full && !pop) overflow <= 1'b1;
    end

`ifdef I2S_READER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst || !enable) sample_count <= '0;
        else if (push && (!full || pop)) sample_count <= sample_count + 32'd1;
    end
`endif
endmodule

// File: tb/tb_i2s_reader.sv
// Bench for i2s_reader: drives I2S frames slot by slot and predicts the popped samples from the slot table.
`timescale 1ns/1ps
module tb_i2s_reader;
    localparam int LIMIT = 8000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        i2s_clock = 1'b0;
    logic        i2s_lr = 1'b1;
    logic        i2s_data = 1'b0;
    logic [23:0] audio_data;
    logic        audio_lr_bit;
    logic        audio_data_valid;
    logic        audio_data_ack = 1'b0;
    logic        overflow;
`ifdef I2S_READER_STATS_EN
    logic [31:0] sample_count;
`endif

    int checks = 0;
    int failures = 0;

    logic [31:0] slot_word [16];
    int          slot_len  [16];
    int          nslots = 0;
    logic [24:0] expq [$];
    bit          ack_rand = 1'b0;
    bit          ovf_chk = 1'b1;
    int          cur_slot = -1;
    int          cur_bit = 0;
    int          pulse_slot = -1;
    bit          prev_hold = 1'b0;
    logic [24:0] prev_head = '0;

    i2s_reader #(.FIFO_DEPTH(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .i2s_clock        (i2s_clock),
        .i2s_lr           (i2s_lr),
        .i2s_data         (i2s_data),
        .audio_data       (audio_data),
        .audio_lr_bit     (audio_lr_bit),
        .audio_data_valid (audio_data_valid),
        .audio_data_ack   (audio_data_ack),
        .overflow         (overflow)
`ifdef I2S_READER_STATS_EN
        ,
        .sample_count     (sample_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Slot 0 is right, then left/right alternate.
    function automatic logic slot_ch(input int k);
        return (k % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // What a receiver must deliver for slot k: MSB-aligned 24 bits, truncated or zero-filled.
    function automatic logic [24:0] slot_sample(input int k);
        logic [31:0] w;
        logic [23:0] v;
        w = slot_word[k];
        if (slot_len[k] >= 24) v = 24'(w >> (slot_len[k] - 24));
        else v = 24'(w << (24 - slot_len[k]));
        return {slot_ch(k), v};
    endfunction

    task automatic expect_slots(input int first, input int last);
        for (int k = first; k <= last; k++) expq.push_back(slot_sample(k));
    endtask

    task automatic set_slot(input int k, input int len, input logic [31:0] w);
        slot_len[k] = len;
        slot_word[k] = (len == 32) ? w : (w & ((32'd1 << len) - 32'd1));
    endtask

    task automatic setup_random(input int n);
        int lens [5] = '{16, 20, 24, 25, 32};
        nslots = n;
        for (int k = 0; k < n; k++) set_slot(k, lens[$urandom_range(0, 4)], $urandom);
    endtask

    // Standard I2S: LR switches one bit before the MSB of the new slot.
    task automatic drive_stream(input int half);
        for (int k = 0; k < nslots; k++) begin
            for (int b = 0; b < slot_len[k]; b++) begin
                cur_slot = k;
                cur_bit = b;
                i2s_clock = 1'b0;
                i2s_data = slot_word[k][slot_len[k] - 1 - b];
                i2s_lr = (b == slot_len[k] - 1 && k + 1 < nslots) ? slot_ch(k + 1) : slot_ch(k);
                repeat (half) @(posedge clk);
                #1;
                i2s_clock = 1'b1;
                if (k == pulse_slot && b == slot_len[k] - 1) begin
                    // Ack lands on the push cycle: three clk edges after the pin rises.
                    fork
                        begin
                            @(posedge clk);
                            @(posedge clk);
                            #1 audio_data_ack = 1'b1;
                            @(posedge clk);
                            #1 audio_data_ack = 1'b0;
                        end
                    join_none
                end
                repeat (half) @(posedge clk);
                #1;
            end
        end
        i2s_clock = 1'b0;
        cur_slot = -1;
    endtask

    task automatic restart();
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1 enable = 1'b1;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_pos(input string name, input int s, input int b);
        int n = 0;
        while (!(cur_slot == s && cur_bit >= b) && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(n < LIMIT), 32'd1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (cur_slot != -1 && n < 4 * LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(n < 4 * LIMIT), 32'd1);
    endtask

    task automatic drain(input string name);
        int n = 0;
        ack_rand = 1'b1;
        while ((expq.size() != 0 || audio_data_valid) && n < LIMIT) begin
            @(posedge clk);
            #1;
            n++;
        end
        ack_rand = 1'b0;
        audio_data_ack = 1'b0;
        check(name, 32'(expq.size()), 32'd0);
        check("valid_after_drain", 32'(audio_data_valid), 32'd0);
    endtask

    task automatic pop_one();
        audio_data_ack = 1'b1;
        @(posedge clk);
        #1 audio_data_ack = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (ack_rand) audio_data_ack = 1'($urandom_range(0, 1));
        end
    end

    // Every handshake must deliver the next predicted sample; a stalled head must not move.
    initial begin
        forever begin
            @(negedge clk);
            if (rst && enable) begin
                if (prev_hold && audio_data_valid)
                    check("head_stable", 32'({audio_lr_bit, audio_data}), 32'(prev_head));
                if (audio_data_valid && audio_data_ack) begin
                    if (expq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL extra_sample: got 0x%0h, required none", {audio_lr_bit, audio_data});
                    end else begin
                        check("sample", 32'({audio_lr_bit, audio_data}), 32'(expq.pop_front()));
                    end
                end
                if (ovf_chk) check("overflow_clear", 32'(overflow), 32'd0);
                prev_hold = audio_data_valid && !audio_data_ack;
                prev_head = {audio_lr_bit, audio_data};
            end else begin
                prev_hold = 1'b0;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_data", 32'(audio_data), 32'd0);
        check("reset_lr", 32'(audio_lr_bit), 32'd0);
        check("reset_valid", 32'(audio_data_valid), 32'd0);
        check("reset_overflow", 32'(overflow), 32'd0);
`ifdef I2S_READER_STATS_EN
        check("reset_count", sample_count, 32'd0);
`endif
        rst = 1'b1;

        // Stereo 32-bit slots at ratio 16; trailing bits beyond 24 must be ignored.
        nslots = 4;
        set_slot(0, 32, 32'hDEADBEEF);
        set_slot(1, 32, 32'hABCDEF5A);
        set_slot(2, 32, 32'h1234567C);
        set_slot(3, 8, 32'h000000A5);
        restart();
        expect_slots(1, 2);
        drive_stream(8);
        check("stereo_valid", 32'(audio_data_valid), 32'd1);
        check("stereo_left", 32'(audio_data), 32'hABCDEF);
        check("stereo_left_lr", 32'(audio_lr_bit), 32'd0);
        pop_one();
        check("stereo_right", 32'(audio_data), 32'h123456);
        check("stereo_right_lr", 32'(audio_lr_bit), 32'd1);
        drain("stereo_drain");

        // 16-bit slots at the minimum ratio 8: LSBs zero-filled.
        nslots = 4;
        set_slot(0, 16, 32'h5555);
        set_slot(1, 16, 32'hBEEF);
        set_slot(2, 16, 32'h1234);
        set_slot(3, 4, 32'h3);
        restart();
        expect_slots(1, 2);
        drive_stream(4);
        check("short_slot", 32'(audio_data), 32'hBEEF00);
        check("short_slot_lr", 32'(audio_lr_bit), 32'd0);
        drain("short_drain");

        // Ack held low, five samples: fifth dropped, overflow sticky until disable.
        setup_random(7);
        restart();
        ovf_chk = 1'b0;
        expect_slots(1, 4);
        drive_stream(5);
        check("overflow_set", 32'(overflow), 32'd1);
        check("full_valid", 32'(audio_data_valid), 32'd1);
        drain("overflow_drain");
        check("overflow_sticky", 32'(overflow), 32'd1);
        restart();
        check("overflow_cleared", 32'(overflow), 32'd0);
        ovf_chk = 1'b1;

        // Pop coinciding with the push on a full FIFO: nothing lost.
        setup_random(7);
        restart();
        expect_slots(1, 5);
        pulse_slot = 5;
        drive_stream(5);
        pulse_slot = -1;
        check("coincide_no_overflow", 32'(overflow), 32'd0);
        drain("coincide_drain");

        // Enable dropped mid-slot with two samples queued, then re-enabled mid-slot.
        nslots = 7;
        for (int k = 0; k < 7; k++) set_slot(k, 32, $urandom);
        restart();
        expect_slots(1, 2);
        fork
            drive_stream(6);
        join_none
        wait_pos("wait_disable", 3, 5);
        check("queued_before_disable", 32'(expq.size()), 32'd2);
        check("valid_before_disable", 32'(audio_data_valid), 32'd1);
        enable = 1'b0;
        @(posedge clk);
        #1;
        check("disable_valid", 32'(audio_data_valid), 32'd0);
        check("disable_overflow", 32'(overflow), 32'd0);
        expq.delete();
        wait_pos("wait_reenable", 3, 12);
        enable = 1'b1;
        expect_slots(4, 5);
        wait_done("disable_stream_done");
        drain("reenable_drain");

        // One-cycle reset in the middle of a frame.
        nslots = 6;
        for (int k = 0; k < 6; k++) set_slot(k, 32, $urandom);
        restart();
        expect_slots(1, 1);
        fork
            drive_stream(6);
        join_none
        wait_pos("wait_reset", 2, 10);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("midreset_data", 32'(audio_data), 32'd0);
        check("midreset_lr", 32'(audio_lr_bit), 32'd0);
        check("midreset_valid", 32'(audio_data_valid), 32'd0);
        check("midreset_overflow", 32'(overflow), 32'd0);
`ifdef I2S_READER_STATS_EN
        check("midreset_count", sample_count, 32'd0);
`endif
        rst = 1'b1;
        expq.delete();
        expect_slots(3, 4);
        begin
            int n = 0;
            while (!audio_data_valid && n < 4 * LIMIT) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("wait_after_reset", 32'(n < 4 * LIMIT), 32'd1);
        end
`ifdef I2S_READER_STATS_EN
        check("count_after_push", sample_count, 32'd1);
`endif
        wait_done("reset_stream_done");
        drain("reset_drain");

        // Random slot lengths, contents and bit-clock ratios with random ack.
        for (int r = 0; r < 6; r++) begin
            setup_random($urandom_range(4, 8));
            restart();
            expect_slots(1, nslots - 2);
            ack_rand = 1'b1;
            drive_stream($urandom_range(4, 6));
            drain("random_drain");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
